trace_buffer: RTL and testbench

- Elastic record buffer directly downstream of the trace unit.
- Captures every trace_output record strobed by the trace unit's trace_data_ready/trace_data_o pair. The producer cannot be stalled.
- Presents records to a drain consumer (host-link serialiser or debug memory writer) over a valid/ready handshake.
- Tags each record with a sequence number. Counts records lost to overflow so software can detect gaps.

---
 rtl/trace_buffer_if.sv | 14 +
 rtl/trace_buffer.sv | 61 ++++++
 tb/tb_trace_buffer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/trace_buffer_if.sv
// trace_buffer_if: producer strobe and drain valid/ready handshake for trace_buffer
interface trace_buffer_if #(
  parameter type data_t = logic [63:0],
  parameter int SEQ_WIDTH = 16
);
  logic trace_data_ready;
  data_t trace_data_i;
  logic out_valid;
  logic out_ready;
  data_t out_data;
  logic [SEQ_WIDTH-1:0] out_seq;
  modport master (output trace_data_ready, trace_data_i, out_ready, input out_valid, out_data, out_seq);
  modport slave (input trace_data_ready, trace_data_i, out_ready, output out_valid, out_data, out_seq);
endinterface

// File: rtl/trace_buffer.sv
// trace_buffer: elastic record buffer with sequence tags and overflow statistics
module trace_buffer #(
  parameter int DEPTH = 8,
  parameter int SEQ_WIDTH = 16,
  parameter int DROP_WIDTH = 16,
  parameter type data_t = logic [63:0]
) (
  input  logic clk,
  input  logic rst,
  trace_buffer_if.slave bus,
  input  logic clear_stats,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH+1)-1:0] high_water,
  output logic overflow,
  output logic [DROP_WIDTH-1:0] drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  data_t mem [DEPTH];
  logic [SEQ_WIDTH-1:0] seq_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [SEQ_WIDTH-1:0] seq;
  logic pop, push, drop;
  logic [CW-1:0] next_count, hw_base;
  assign pop = bus.out_valid && bus.out_ready;
  // a pop frees the slot in the same cycle, so push at full is lossless
  assign push = bus.trace_data_ready && (count != FULL || pop);
  assign drop = bus.trace_data_ready && !push;
  assign next_count = count + CW'(push) - CW'(pop);
  assign hw_base = clear_stats ? '0 : high_water;
  assign bus.out_valid = count != '0;
  assign bus.out_data = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.out_seq = bus.out_valid ? seq_mem[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.trace_data_i;
      seq_mem[wr_ptr] <= seq;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      seq <= '0;
      count <= '0;
      high_water <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      seq <= seq + SEQ_WIDTH'(bus.trace_data_ready);
      count <= next_count;
      high_water <= next_count > hw_base ? next_count : hw_base;
      overflow <= (overflow && !clear_stats) || drop;
      drop_count <= clear_stats ? DROP_WIDTH'(drop)
                  : drop_count + DROP_WIDTH'(drop && drop_count != '1);
    end
  end
endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer: directed stimulus with a queue scoreboard checked by an independent drain monitor
module tb_trace_buffer;
  typedef logic [15:0] data_t;
  logic clk = 0, rst = 1, clear_stats = 0;
  logic [2:0] count, high_water;
  logic overflow;
  logic [1:0] drop_count;
  int tests = 0, fails = 0;
  logic [15:0] seq_m = 0;
  logic [31:0] q [$];
  trace_buffer_if #(.data_t(data_t), .SEQ_WIDTH(16)) bus ();
  trace_buffer #(.DEPTH(4), .SEQ_WIDTH(16), .DROP_WIDTH(2), .data_t(data_t)) dut (
    .clk(clk), .rst(rst), .bus(bus), .clear_stats(clear_stats), .count(count),
    .high_water(high_water), .overflow(overflow), .drop_count(drop_count));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input data_t d, input bit acc);
    bus.trace_data_ready = 1;
    bus.trace_data_i = d;
    if (acc) q.push_back({d, seq_m});
    seq_m++;
    step;
    bus.trace_data_ready = 0;
  endtask
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL drain: unexpected record %0h/%0h", bus.out_data, bus.out_seq);
      end else begin
        logic [31:0] e;
        e = q.pop_front();
        if ({bus.out_data, bus.out_seq} !== e) begin
          fails++;
          $display("FAIL drain: got data %0h seq %0h expected data %0h seq %0h",
                   bus.out_data, bus.out_seq, e[31:16], e[15:0]);
        end
      end
    end
  end
  initial begin
    bus.trace_data_ready = 0;
    bus.trace_data_i = '0;
    bus.out_ready = 0;
    step; step;
    rst = 0;
    step;
    check("reset valid", bus.out_valid, 0);
    check("reset count", count, 0);
    check("reset stats", {high_water, overflow, drop_count}, 0);
    check("idle data", {bus.out_data, bus.out_seq}, 0);
    push(16'hA000, 1);
    check("valid after A", bus.out_valid, 1);
    push(16'hB001, 1);
    push(16'hC002, 1);
    check("head A", {bus.out_data, bus.out_seq}, {16'hA000, 16'd0});
    check("count 3", count, 3);
    check("hw 3", high_water, 3);
    push(16'hD003, 1);
    push(16'hE004, 0);
    push(16'hF005, 0);
    check("full count", count, 4);
    check("overflow", overflow, 1);
    check("drop 2", drop_count, 2);
    check("hw 4", high_water, 4);
    bus.out_ready = 1;
    repeat (4) step;
    bus.out_ready = 0;
    check("drained", count, 0);
    push(16'h6006, 1);
    check("seq after gap", bus.out_seq, 6);
    push(16'h7007, 1);
    push(16'h8008, 1);
    push(16'h9009, 1);
    bus.out_ready = 1;
    push(16'hA00A, 1);
    check("full push+pop count", count, 4);
    check("full push+pop no drop", drop_count, 2);
    repeat (4) step;
    check("empty again", count, 0);
    push(16'hB00B, 1);
    for (int i = 0; i < 13; i++) begin
      push(16'hC000 + 16'(i), 1);
      check("stream count", count, 1);
    end
    step;
    bus.out_ready = 0;
    check("stream drained", count, 0);
    clear_stats = 1;
    step;
    clear_stats = 0;
    check("clear stats", {high_water, overflow, drop_count}, 0);
    for (int i = 0; i < 4; i++) push(16'h1000 + 16'(i), 1);
    for (int i = 0; i < 5; i++) push(16'h2000 + 16'(i), 0);
    check("drop saturate", drop_count, 3);
    check("overflow again", overflow, 1);
    clear_stats = 1;
    push(16'h3000, 0);
    clear_stats = 0;
    check("clear+drop count", drop_count, 1);
    check("clear+drop overflow", overflow, 1);
    check("clear hw loads count", high_water, 4);
    bus.out_ready = 1;
    step;
    bus.out_ready = 0;
    check("mid drain count", count, 3);
    rst = 1;
    q.delete();
    step;
    rst = 0;
    seq_m = 0;
    check("rst valid", bus.out_valid, 0);
    check("rst count", count, 0);
    check("rst stats", {high_water, overflow, drop_count}, 0);
    push(16'h4444, 1);
    check("seq restart", bus.out_seq, 0);
    bus.out_ready = 1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step;
    check("scoreboard empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
